pipeline_hazard_unit: RTL and testbench

Central hazard controller for the five-stage pipeline (IF, ID, EX, MEM, WB). It tracks destination registers of in-flight instructions in a shadow pipeline and issues the stall, flush and forwarding controls that keep the datapath correct. It also sequences start, halt and drain for the whole core. It sits beside the decode-stage controller, consumes its decoded control bits, and drives the IF/ID and ID/EX pipeline-register enables and clears.

---
 rtl/pipeline_hazard_unit.sv | 145 ++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB destination tracking,
// stall/flush/forward control and IDLE/RUN/DRAIN sequencing. Optional macro: FORWARDING_EN.
module pipeline_hazard_unit #(
  parameter int RA_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            idValid,
  input  logic [RA_W-1:0] idRs1,
  input  logic [RA_W-1:0] idRs2,
  input  logic            idUsesRs1,
  input  logic            idUsesRs2,
  input  logic [RA_W-1:0] idRd,
  input  logic            idRegWriteEn,
  input  logic            idLdm,
  input  logic            idHalt,
  input  logic            exRedirect,
  output logic            stall,
  output logic            flushId,
  output logic            flushEx,
  output logic [1:0]      fwdA,
  output logic [1:0]      fwdB,
  output logic            drained
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            wr;
    logic            ld;
  } shadow_t;

  state_t  r_state;
  state_t  w_state_nxt;
  shadow_t r_ex;
  shadow_t r_mem;
  shadow_t r_wb;
  shadow_t w_id_entry;
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic w_ex_a, w_ex_b, w_mem_a, w_mem_b, w_wb_a, w_wb_b;
  logic w_hazard;
  logic w_issue;
  logic w_shadow_empty;
  logic w_unused;

  function automatic logic src_match(input shadow_t e, input logic [RA_W-1:0] src,
                                     input logic uses);
    return uses & e.valid & e.wr & (e.rd == src);
  endfunction

  assign w_ex_a  = src_match(r_ex,  idRs1, idUsesRs1);
  assign w_ex_b  = src_match(r_ex,  idRs2, idUsesRs2);
  assign w_mem_a = src_match(r_mem, idRs1, idUsesRs1);
  assign w_mem_b = src_match(r_mem, idRs2, idUsesRs2);
  assign w_wb_a  = src_match(r_wb,  idRs1, idUsesRs1);
  assign w_wb_b  = src_match(r_wb,  idRs2, idUsesRs2);

`ifdef FORWARDING_EN
  // Only a load still in EX cannot be bypassed; the youngest producer wins the select.
  assign w_hazard = idValid & r_ex.ld & (w_ex_a | w_ex_b);
  assign w_fwd_a  = w_ex_a ? 2'b01 : (w_mem_a ? 2'b10 : 2'b00);
  assign w_fwd_b  = w_ex_b ? 2'b01 : (w_mem_b ? 2'b10 : 2'b00);
  assign w_unused = ^{w_wb_a, w_wb_b, r_wb.ld};
`else
  // WB is included because the register file write and the ID read share an edge.
  assign w_hazard = idValid & (w_ex_a | w_ex_b | w_mem_a | w_mem_b | w_wb_a | w_wb_b);
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
  assign w_unused = r_wb.ld;
`endif

  assign w_id_entry     = {1'b1, idRd, idRegWriteEn, idLdm};
  assign w_shadow_empty = ~r_ex.valid & ~r_mem.valid & ~r_wb.valid;
  assign w_issue        = (r_state == S_RUN) & idValid & ~stall & ~exRedirect & ~idHalt;

  // NOTE: every output of this block gets a default first so no path leaves a latch.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    flushId     = 1'b0;
    flushEx     = 1'b0;
    drained     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        stall   = 1'b1;
        drained = 1'b1;
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (exRedirect) begin
          flushId = 1'b1;
          flushEx = 1'b1;
        end else if (w_hazard) begin
          stall   = 1'b1;
          flushEx = 1'b1;
        end else if (idValid & idHalt) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        stall   = 1'b1;
        flushEx = 1'b1;
        flushId = exRedirect;
        drained = w_shadow_empty;
        if (w_shadow_empty) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != S_IDLE) begin
        r_wb  <= r_mem;
        r_mem <= r_ex;
        r_ex  <= w_issue ? w_id_entry : '0;
      end
      r_fwd_a <= w_issue ? w_fwd_a : 2'b00;
      r_fwd_b <= w_issue ? w_fwd_b : 2'b00;
    end
  end

  assign fwdA = r_fwd_a;
  assign fwdB = r_fwd_b;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: per-cycle expected controls are queued at
// drive time and compared on the falling edge. Expectations follow FORWARDING_EN.
module tb_pipeline_hazard_unit;

  typedef struct packed {
    logic       start;
    logic       valid;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       u1;
    logic       u2;
    logic [2:0] rd;
    logic       we;
    logic       ld;
    logic       halt;
    logic       redir;
  } stim_t;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    logic [7:0] mask;
  } exp_t;

  localparam logic [7:0] M_ALL   = 8'hFF;
  localparam logic [7:0] M_NOFEX = 8'hDF;

  logic clk = 1'b0;
  logic rst;
  logic start, idValid, idUsesRs1, idUsesRs2, idRegWriteEn, idLdm, idHalt, exRedirect;
  logic [2:0] idRs1, idRs2, idRd;
  logic stall, flushId, flushEx, drained;
  logic [1:0] fwdA, fwdB;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  pipeline_hazard_unit #(.RA_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .idValid(idValid),
    .idRs1(idRs1), .idRs2(idRs2), .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .idRd(idRd), .idRegWriteEn(idRegWriteEn), .idLdm(idLdm), .idHalt(idHalt),
    .exRedirect(exRedirect), .stall(stall), .flushId(flushId), .flushEx(flushEx),
    .fwdA(fwdA), .fwdB(fwdB), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b  {stall,flushId,flushEx,drained,fwdA,fwdB}",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {stall, flushId, flushEx, drained, fwdA, fwdB};
  endfunction

  function automatic logic [7:0] o(input logic st, input logic fi, input logic fe,
                                   input logic dr, input logic [1:0] fa, input logic [1:0] fb);
    return {st, fi, fe, dr, fa, fb};
  endfunction

  function automatic stim_t bub();
    return '0;
  endfunction

  function automatic stim_t alu(input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    stim_t s = '0;
    s.valid = 1'b1; s.rd = rd; s.we = 1'b1;
    s.rs1 = rs1; s.u1 = 1'b1; s.rs2 = rs2; s.u2 = 1'b1;
    return s;
  endfunction

  function automatic stim_t ldi(input logic [2:0] rd, input logic [2:0] rs1);
    stim_t s = '0;
    s.valid = 1'b1; s.rd = rd; s.we = 1'b1; s.ld = 1'b1;
    s.rs1 = rs1; s.u1 = 1'b1;
    return s;
  endfunction

  function automatic stim_t wrr(input logic [2:0] rd);
    stim_t s = '0;
    s.valid = 1'b1; s.rd = rd; s.we = 1'b1;
    return s;
  endfunction

  function automatic stim_t hlt();
    stim_t s = '0;
    s.valid = 1'b1; s.halt = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    start = s.start; idValid = s.valid; idRs1 = s.rs1; idRs2 = s.rs2;
    idUsesRs1 = s.u1; idUsesRs2 = s.u2; idRd = s.rd; idRegWriteEn = s.we;
    idLdm = s.ld; idHalt = s.halt; exRedirect = s.redir;
  endtask

  task automatic cyc(input string tag, input stim_t s, input logic [7:0] exp,
                     input logic [7:0] mask);
    exp_t e;
    @(posedge clk);
    #1;
    apply(s);
    e.tag = tag; e.exp = exp; e.mask = mask;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, outs() & e.mask, e.exp & e.mask);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [7:0] zz;
    logic [7:0] sf;
    zz = o(0, 0, 0, 0, 2'b00, 2'b00);
    sf = o(1, 0, 1, 0, 2'b00, 2'b00);
    rst = 1'b1;
    apply(bub());
    #1 check("reset", outs(), o(1, 0, 0, 1, 2'b00, 2'b00));
    #12 rst = 1'b0;

    // start, then independent ALU ops issue back to back
    s = bub(); s.start = 1'b1;
    cyc("start_idle", s, o(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    cyc("run_entry", bub(), zz, M_ALL);
    cyc("indep1", alu(3'd1, 3'd4, 3'd5), zz, M_ALL);
    cyc("indep2", alu(3'd2, 3'd5, 3'd6), zz, M_ALL);
    cyc("indep3", alu(3'd3, 3'd6, 3'd7), zz, M_ALL);
    cyc("indep4", alu(3'd4, 3'd7, 3'd5), zz, M_ALL);
    repeat (3) cyc("settle_a", bub(), zz, M_ALL);

    // dependent ALU chain on r3
`ifdef FORWARDING_EN
    cyc("dep_prod", alu(3'd3, 3'd1, 3'd2), zz, M_ALL);
    cyc("dep_cons1", alu(3'd5, 3'd3, 3'd6), zz, M_ALL);
    cyc("dep_cons2_fwdA01", alu(3'd6, 3'd3, 3'd7), o(0, 0, 0, 0, 2'b01, 2'b00), M_ALL);
    cyc("dep_fwdA10", bub(), o(0, 0, 0, 0, 2'b10, 2'b00), M_ALL);
    repeat (2) cyc("settle_b", bub(), zz, M_ALL);
`else
    cyc("dep_prod", alu(3'd3, 3'd1, 3'd2), zz, M_ALL);
    repeat (3) cyc("dep_stall", alu(3'd5, 3'd3, 3'd6), sf, M_ALL);
    cyc("dep_issue", alu(3'd5, 3'd3, 3'd6), zz, M_ALL);
    cyc("dep_cons2", alu(3'd6, 3'd3, 3'd7), zz, M_ALL);
    repeat (3) cyc("settle_b", bub(), zz, M_ALL);
`endif

    // load to r2, reader of r2 on Rs2
`ifdef FORWARDING_EN
    cyc("ld_prod", ldi(3'd2, 3'd1), zz, M_ALL);
    cyc("ld_use_stall", alu(3'd4, 3'd5, 3'd2), sf, M_ALL);
    cyc("ld_use_issue", alu(3'd4, 3'd5, 3'd2), zz, M_ALL);
    cyc("ld_use_fwdB10", bub(), o(0, 0, 0, 0, 2'b00, 2'b10), M_ALL);
    repeat (2) cyc("settle_c", bub(), zz, M_ALL);
`else
    cyc("ld_prod", ldi(3'd2, 3'd1), zz, M_ALL);
    repeat (3) cyc("ld_use_stall", alu(3'd4, 3'd5, 3'd2), sf, M_ALL);
    cyc("ld_use_issue", alu(3'd4, 3'd5, 3'd2), zz, M_ALL);
    repeat (3) cyc("settle_c", bub(), zz, M_ALL);
`endif

    // redirect while load-use pair sits in ID/EX; squashed r4 writer must not forward/stall
    cyc("rd_ld", ldi(3'd2, 3'd1), zz, M_ALL);
    s = alu(3'd4, 3'd5, 3'd2); s.redir = 1'b1;
    cyc("redirect", s, o(0, 1, 1, 0, 2'b00, 2'b00), M_ALL);
    cyc("post_redirect", alu(3'd6, 3'd4, 3'd3), zz, M_ALL);
    cyc("squashed_fwd", bub(), zz, M_ALL);
    repeat (2) cyc("settle_d", bub(), zz, M_ALL);

    // halt behind three writers, drain, restart, halt squashed by redirect
    cyc("w1", wrr(3'd1), zz, M_ALL);
    cyc("w2", wrr(3'd2), zz, M_ALL);
    cyc("w3", wrr(3'd3), zz, M_ALL);
    cyc("halt_id", hlt(), zz, M_NOFEX);
    cyc("drain1", bub(), sf, M_ALL);
    cyc("drain2", bub(), sf, M_ALL);
    cyc("drained", bub(), o(1, 0, 1, 1, 2'b00, 2'b00), M_ALL);
    cyc("idle", bub(), o(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    s = bub(); s.start = 1'b1;
    cyc("restart", s, o(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    cyc("rerun", bub(), zz, M_ALL);
    s = hlt(); s.redir = 1'b1;
    cyc("halt_redirect", s, o(0, 1, 1, 0, 2'b00, 2'b00), M_ALL);
    cyc("halt_squashed", bub(), zz, M_ALL);

    // asynchronous reset while draining
    cyc("f_wr", wrr(3'd1), zz, M_ALL);
    cyc("f_halt", hlt(), zz, M_NOFEX);
    cyc("f_drain", bub(), sf, M_ALL);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", outs(), o(1, 0, 0, 1, 2'b00, 2'b00));
    @(posedge clk);
    #3 rst = 1'b0;
    cyc("post_rst_idle", bub(), o(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    s = bub(); s.start = 1'b1;
    cyc("post_rst_start", s, o(1, 0, 0, 1, 2'b00, 2'b00), M_ALL);
    cyc("post_rst_read_r1", alu(3'd5, 3'd1, 3'd1), zz, M_ALL);
    cyc("post_rst_fwd", bub(), zz, M_ALL);

    @(negedge clk);
    #1;
    check("sb_drained", {7'd0, sb.size() == 0}, 8'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
